wb_dma_ram_arb: RTL and testbench



---
 rtl/wb_dma_ram_arb.sv | 171 +++++++++++++++++
 tb/tb_wb_dma_ram_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dma_ram_arb.sv
// Shared single-port RAM serving one Wishbone slave and NUM_CH DMA channels through a
// round-robin arbiter. Define WB_DMA_RAM_ERR_EN to add err outputs for out-of-range accesses.
module wb_dma_ram_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH*DATA_WIDTH/8),
    parameter int NUM_CH     = 2
) (
    input  logic                           wb_clk,
    input  logic                           wb_rst,
    input  logic [ADDR_WIDTH-1:0]          wb_adr_i,
    input  logic [DATA_WIDTH-1:0]          wb_dat_i,
    output logic [DATA_WIDTH-1:0]          wb_dat_o,
    input  logic                           wb_we_i,
    input  logic [DATA_WIDTH/8-1:0]        wb_sel_i,
    input  logic                           wb_stb_i,
    input  logic                           wb_cyc_i,
    output logic                           wb_ack_o,
    output logic                           wb_stall_o,
`ifdef WB_DMA_RAM_ERR_EN
    output logic                           wb_err_o,
    output logic [NUM_CH-1:0]              ch_err_o,
`endif
    input  logic [NUM_CH-1:0]              ch_req_i,
    input  logic [NUM_CH-1:0]              ch_we_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_adr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_dat_i,
    output logic [DATA_WIDTH-1:0]          ch_dat_o,
    output logic [NUM_CH-1:0]              ch_ack_o
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFF  = (NB > 1) ? $clog2(NB) : 0;
    localparam int MW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NREQ = NUM_CH + 1;
    localparam int GW   = $clog2(NREQ);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [GW-1:0]         last_q, last_d;
    logic                  wb_ack_q, wb_ack_d;
    logic                  wb_err_q, wb_err_d;
    logic [NUM_CH-1:0]     ch_ack_q, ch_ack_d;
    logic [NUM_CH-1:0]     ch_err_q, ch_err_d;
    logic [DATA_WIDTH-1:0] wb_dat_q, wb_dat_d;
    logic [DATA_WIDTH-1:0] ch_dat_q, ch_dat_d;

    logic [NREQ-1:0]       req;
    logic                  gnt_vld;
    logic [GW-1:0]         gnt_idx;
    logic                  wb_hit;
    logic [NUM_CH-1:0]     ch_hit;

    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_adr;
    logic [DATA_WIDTH-1:0] acc_dat;
    logic [NB-1:0]         acc_be;
    logic [31:0]           acc_word32;
    logic                  in_range;
    logic [MW-1:0]         mem_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_bits;

    // A requester whose response is on the bus this cycle is masked so a held
    // request is not issued a second time.
    always_comb begin
        req    = '0;
        req[0] = wb_cyc_i & wb_stb_i & ~(wb_ack_q | wb_err_q);
        for (int k = 0; k < NUM_CH; k++)
            req[k+1] = ch_req_i[k] & ~(ch_ack_q[k] | ch_err_q[k]);
    end

    always_comb begin
        int cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NREQ)
                cand = cand - NREQ;
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = GW'(cand);
            end
        end
    end

    always_comb begin
        acc_we  = wb_we_i;
        acc_adr = wb_adr_i;
        acc_dat = wb_dat_i;
        acc_be  = wb_sel_i;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_idx == GW'(k + 1)) begin
                acc_we  = ch_we_i[k];
                acc_adr = ch_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                acc_dat = ch_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                acc_be  = '1;
            end
        end
    end

    assign acc_word32  = 32'(acc_adr[ADDR_WIDTH-1:OFF]);
    assign in_range    = acc_word32 < 32'(DEPTH);
    assign mem_idx     = acc_word32[MW-1:0];
    assign rd_word     = in_range ? mem[mem_idx] : '0;
    assign unused_bits = ^{acc_word32, acc_adr};

    // No reset on the array; an access granted while reset is asserted is dropped.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst && gnt_vld && acc_we && in_range) begin
            for (int b = 0; b < NB; b++)
                if (acc_be[b])
                    mem[mem_idx][8*b +: 8] <= acc_dat[8*b +: 8];
        end
    end

    always_comb begin
        wb_hit = gnt_vld && (gnt_idx == '0);
        ch_hit = '0;
        for (int k = 0; k < NUM_CH; k++)
            ch_hit[k] = gnt_vld && (gnt_idx == GW'(k + 1));
        last_d = gnt_vld ? gnt_idx : last_q;
`ifdef WB_DMA_RAM_ERR_EN
        wb_ack_d = wb_hit & in_range;
        wb_err_d = wb_hit & ~in_range;
        ch_ack_d = ch_hit & {NUM_CH{in_range}};
        ch_err_d = ch_hit & {NUM_CH{~in_range}};
`else
        wb_ack_d = wb_hit;
        wb_err_d = 1'b0;
        ch_ack_d = ch_hit;
        ch_err_d = '0;
`endif
        // rd_word is the pre-write contents, giving read-first behaviour.
        wb_dat_d = wb_hit ? rd_word : wb_dat_q;
        ch_dat_d = (|ch_hit) ? rd_word : ch_dat_q;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            last_q   <= GW'(NUM_CH);
            wb_ack_q <= 1'b0;
            wb_err_q <= 1'b0;
            ch_ack_q <= '0;
            ch_err_q <= '0;
            wb_dat_q <= '0;
            ch_dat_q <= '0;
        end else begin
            last_q   <= last_d;
            wb_ack_q <= wb_ack_d;
            wb_err_q <= wb_err_d;
            ch_ack_q <= ch_ack_d;
            ch_err_q <= ch_err_d;
            wb_dat_q <= wb_dat_d;
            ch_dat_q <= ch_dat_d;
        end
    end

    assign wb_stall_o = req[0] & ~wb_hit & ~wb_rst;
    assign wb_ack_o   = wb_ack_q;
    assign ch_ack_o   = ch_ack_q;
    assign wb_dat_o   = wb_dat_q;
    assign ch_dat_o   = ch_dat_q;
`ifdef WB_DMA_RAM_ERR_EN
    assign wb_err_o   = wb_err_q;
    assign ch_err_o   = ch_err_q;
`endif

endmodule

// File: tb/tb_wb_dma_ram_arb.sv
// Directed bench for wb_dma_ram_arb (DEPTH=1000 so out-of-range words exist): a WB vector
// table plus hand sequences for round-robin, channel conflicts and reset during a grant.
`timescale 1ns/1ps
module tb_wb_dma_ram_arb;
    localparam int DW     = 32;
    localparam int DEPTH  = 1000;
    localparam int NUM_CH = 2;
    localparam int AW     = $clog2(DEPTH*DW/8);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [AW-1:0]        wb_adr;
    logic [DW-1:0]        wb_dat, wb_dat_o;
    logic                 wb_we, wb_stb, wb_cyc, wb_ack_o, wb_stall_o;
    logic [DW/8-1:0]      wb_sel;
    logic [NUM_CH-1:0]    ch_req, ch_we, ch_ack_o;
    logic [NUM_CH*AW-1:0] ch_adr;
    logic [NUM_CH*DW-1:0] ch_dat;
    logic [DW-1:0]        ch_dat_o;
`ifdef WB_DMA_RAM_ERR_EN
    logic                 wb_err_o;
    logic [NUM_CH-1:0]    ch_err_o;
`endif

    always #5 clk = ~clk;

    wb_dma_ram_arb #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
        .wb_clk(clk), .wb_rst(rst),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we),
        .wb_sel_i(wb_sel), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_ack_o(wb_ack_o),
        .wb_stall_o(wb_stall_o),
`ifdef WB_DMA_RAM_ERR_EN
        .wb_err_o(wb_err_o), .ch_err_o(ch_err_o),
`endif
        .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_adr_i(ch_adr), .ch_dat_i(ch_dat),
        .ch_dat_o(ch_dat_o), .ch_ack_o(ch_ack_o)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
        logic          chk;
        logic [31:0]   exp;
        logic          oor;
    } vec_t;

    localparam int NV = 17;
    vec_t tab [NV];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic chk, input logic [31:0] exp,
                                input logic oor);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.chk = chk; v.exp = exp; v.oor = oor;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst wb_ack", 32'(wb_ack_o), 0);
        check("rst ch_ack", 32'(ch_ack_o), 0);
        check("rst wb_dat", wb_dat_o, 0);
        check("rst ch_dat", ch_dat_o, 0);
        check("rst stall", 32'(wb_stall_o), 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Entered and left just after a rising edge.
    task automatic wb_xfer(input vec_t v, input int id);
        int   lat;
        logic resp, exp_ack;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = v.we; wb_adr = v.adr; wb_dat = v.dat; wb_sel = v.sel;
        @(negedge clk);
        check($sformatf("v%0d stall", id), 32'(wb_stall_o), 0);
        lat  = 0;
        resp = 1'b0;
        while (!resp && lat < 8) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
`ifdef WB_DMA_RAM_ERR_EN
            resp = wb_ack_o | wb_err_o;
`else
            resp = wb_ack_o;
`endif
        end
        check($sformatf("v%0d latency", id), 32'(lat), 1);
`ifdef WB_DMA_RAM_ERR_EN
        exp_ack = ~v.oor;
        check($sformatf("v%0d err", id), 32'(wb_err_o), 32'(v.oor));
`else
        exp_ack = 1'b1;
`endif
        check($sformatf("v%0d ack", id), 32'(wb_ack_o), 32'(exp_ack));
        if (v.chk) check($sformatf("v%0d data", id), wb_dat_o, v.exp);
        @(posedge clk);
        #1 wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d single ack", id), 32'(wb_ack_o), 0);
        @(posedge clk);
        #1;
    endtask

    // Issues requests on the channels in en and watches 6 cycles; returns first-ack cycle,
    // ack count per channel and ch0's read data.
    task automatic ch_pair(input logic [1:0] en, input logic [1:0] we, input logic [AW-1:0] a0,
                           input logic [AW-1:0] a1, input logic [31:0] d1,
                           output logic [31:0] rd0, output int c0, output int c1,
                           output int n0, output int n1);
        logic [1:0] seen;
        ch_we = we; ch_adr = {a1, a0}; ch_dat = {d1, 32'h0}; ch_req = en;
        c0 = -1; c1 = -1; n0 = 0; n1 = 0; rd0 = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = ch_ack_o;
            if (seen[0]) begin n0++; if (c0 < 0) begin c0 = c; rd0 = ch_dat_o; end end
            if (seen[1]) begin n1++; if (c1 < 0) c1 = c; end
            @(posedge clk);
            #1 ch_req = ch_req & ~seen;
        end
        ch_req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd0;
        int c0, c1, n0, n1, prev;
        logic [1:0] exp_ch;

        tab[0]  = mk(1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0);
        tab[1]  = mk(0, 12'h010, 32'h0,        4'hF, 1, 32'hDEADBEEF, 0);
        tab[2]  = mk(1, 12'h020, 32'h11223344, 4'hF, 0, 32'h0,        0);
        tab[3]  = mk(1, 12'h020, 32'h0000AA00, 4'h2, 0, 32'h0,        0);
        tab[4]  = mk(0, 12'h020, 32'h0,        4'hF, 1, 32'h1122AA44, 0);
        tab[5]  = mk(1, 12'h024, 32'h00000000, 4'hF, 0, 32'h0,        0);
        tab[6]  = mk(1, 12'h024, 32'hAABBCCDD, 4'h9, 0, 32'h0,        0);
        tab[7]  = mk(1, 12'h024, 32'h12345678, 4'hF, 1, 32'hAA0000DD, 0);
        tab[8]  = mk(0, 12'h024, 32'h0,        4'hF, 1, 32'h12345678, 0);
        tab[9]  = mk(1, 12'h01C, 32'h77777777, 4'hF, 0, 32'h0,        0);
        tab[10] = mk(1, 12'hFAC, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        1);
        tab[11] = mk(0, 12'h010, 32'h0,        4'hF, 1, 32'hDEADBEEF, 0);
        tab[12] = mk(0, 12'hFAC, 32'h0,        4'hF, 1, 32'h0,        1);
        tab[13] = mk(0, 12'h010, 32'h0,        4'hF, 1, 32'hDEADBEEF, 0);
        tab[14] = mk(0, 12'hFFC, 32'h0,        4'hF, 1, 32'h0,        1);
        tab[15] = mk(0, 12'h024, 32'h0,        4'hF, 1, 32'h12345678, 0);
        tab[16] = mk(0, 12'h01C, 32'h0,        4'hF, 1, 32'h77777777, 0);

        rst = 1'b1; wb_adr = '0; wb_dat = '0; wb_we = 0; wb_sel = '0; wb_stb = 0; wb_cyc = 0;
        ch_req = '0; ch_we = '0; ch_adr = '0; ch_dat = '0;
        do_reset();

        for (int i = 0; i < NV; i++) wb_xfer(tab[i], i);

        // All three request continuously: WB, ch0, ch1, WB, ...
        do_reset();
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 12'h010; wb_sel = 4'hF;
        ch_we = '0; ch_adr = {12'h020, 12'h010}; ch_req = 2'b11;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            prev   = (c + 2) % 3;
            exp_ch = (c == 0) ? 2'b00 : (prev == 1) ? 2'b01 : (prev == 2) ? 2'b10 : 2'b00;
            check($sformatf("rr%0d wb_ack", c), 32'(wb_ack_o), 32'(c > 0 && prev == 0));
            check($sformatf("rr%0d ch_ack", c), 32'(ch_ack_o), 32'(exp_ch));
            check($sformatf("rr%0d stall", c), 32'(wb_stall_o), 32'(c % 3 == 2));
            if (c > 0 && prev == 0) check($sformatf("rr%0d wb_dat", c), wb_dat_o, 32'hDEADBEEF);
            if (exp_ch == 2'b01) check($sformatf("rr%0d ch0_dat", c), ch_dat_o, 32'hDEADBEEF);
            if (exp_ch == 2'b10) check($sformatf("rr%0d ch1_dat", c), ch_dat_o, 32'h1122AA44);
            @(posedge clk);
            #1;
        end
        wb_cyc = 0; wb_stb = 0; ch_req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("hold wb_dat", wb_dat_o, 32'hDEADBEEF);
        check("hold ch_dat", ch_dat_o, 32'h1122AA44);
        @(posedge clk);
        #1;

        // ch0 reads word 7 while ch1 writes it; ch0 wins first after reset.
        do_reset();
        ch_pair(2'b11, 2'b10, 12'h01C, 12'h01C, 32'h5, rd0, c0, c1, n0, n1);
        check("cfA ch0 data", rd0, 32'h77777777);
        check("cfA ch0 cycle", 32'(c0), 1);
        check("cfA ch1 cycle", 32'(c1), 2);
        check("cfA ch0 acks", 32'(n0), 1);
        check("cfA ch1 acks", 32'(n1), 1);
        ch_pair(2'b01, 2'b00, 12'h01C, 12'h01C, 32'h0, rd0, c0, c1, n0, n1);
        check("cfS ch0 data", rd0, 32'h5);
        check("cfS ch0 cycle", 32'(c0), 1);
        // last grant is ch0, so ch1's write now goes first.
        ch_pair(2'b11, 2'b10, 12'h01C, 12'h01C, 32'h6, rd0, c0, c1, n0, n1);
        check("cfB ch0 data", rd0, 32'h6);
        check("cfB ch1 cycle", 32'(c1), 1);
        check("cfB ch0 cycle", 32'(c0), 2);
        check("cfB ch0 acks", 32'(n0), 1);
        check("cfB ch1 acks", 32'(n1), 1);

        // Reset in the cycle ch0 is granted: dropped, then WB goes first.
        ch_we = '0; ch_adr = {12'h000, 12'h010}; ch_req = 2'b01; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 12'h020; wb_sel = 4'hF;
        @(negedge clk);
        check("rg ch_ack after rst", 32'(ch_ack_o), 0);
        check("rg wb first", 32'(wb_stall_o), 0);
        @(posedge clk);
        #1 wb_cyc = 0; wb_stb = 0;
        @(negedge clk);
        check("rg wb_ack", 32'(wb_ack_o), 1);
        check("rg wb_dat", wb_dat_o, 32'h1122AA44);
        check("rg ch_ack idle", 32'(ch_ack_o), 0);
        @(posedge clk);
        @(negedge clk);
        check("rg ch0 ack", 32'(ch_ack_o), 32'h1);
        check("rg ch0 dat", ch_dat_o, 32'hDEADBEEF);
        @(posedge clk);
        #1 ch_req = '0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
